// File: rtl/registrador_id_ex.sv
// ID/EX pipeline register feeding the 64-bit ULA: captures decoded operands behind a
// valid/ready handshake and resolves rs1/rs2 hazards by forwarding from EX and WB.
module registrador_id_ex #(
    parameter int BITS     = 64,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_ADDR-1:0] in_rs1,
    input  logic [REG_ADDR-1:0] in_rs2,
    input  logic [REG_ADDR-1:0] in_rd,
    input  logic [BITS-1:0]     in_dina,
    input  logic [BITS-1:0]     in_dinb,
    input  logic [BITS-1:0]     in_imm,
    input  logic                in_subtraindo,
    input  logic                in_alu_src,
    input  logic [1:0]          in_operacao,
    input  logic                in_reg_write,

    input  logic                flush,

    input  logic [BITS-1:0]     ula_dout,
    input  logic                wb_valid,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic [BITS-1:0]     wb_data,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     dina,
    output logic [BITS-1:0]     dinb,
    output logic [BITS-1:0]     imm,
    output logic                subtraindo,
    output logic                alu_src,
    output logic [1:0]          operacao,
    output logic [REG_ADDR-1:0] rd,
    output logic                reg_write
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; the held instruction stays put while out_valid && !out_ready.

    logic                valid_q, valid_d;
    logic [BITS-1:0]     dina_q, dina_d;
    logic [BITS-1:0]     dinb_q, dinb_d;
    logic [BITS-1:0]     imm_q, imm_d;
    logic                subtraindo_q, subtraindo_d;
    logic                alu_src_q, alu_src_d;
    logic [1:0]          operacao_q, operacao_d;
    logic [REG_ADDR-1:0] rd_q, rd_d;
    logic                reg_write_q, reg_write_d;
    logic [REG_ADDR-1:0] rs1_q, rs1_d;
    logic [REG_ADDR-1:0] rs2_q, rs2_d;

    logic                accept;
    logic                ex_fwd_ok;
    logic                wb_fwd_ok;
    logic [BITS-1:0]     fwd_a;
    logic [BITS-1:0]     fwd_b;

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign ex_fwd_ok = valid_q && reg_write_q && (rd_q != '0);
    assign wb_fwd_ok = wb_valid && (wb_rd != '0);

    // EX result is the newest value of rd, so it wins over writeback.
    always_comb begin
        fwd_a = in_dina;
        if (ex_fwd_ok && (rd_q == in_rs1)) begin
            fwd_a = ula_dout;
        end else if (wb_fwd_ok && (wb_rd == in_rs1)) begin
            fwd_a = wb_data;
        end

        fwd_b = in_dinb;
        if (ex_fwd_ok && (rd_q == in_rs2)) begin
            fwd_b = ula_dout;
        end else if (wb_fwd_ok && (wb_rd == in_rs2)) begin
            fwd_b = wb_data;
        end
    end

    always_comb begin
        valid_d      = valid_q;
        dina_d       = dina_q;
        dinb_d       = dinb_q;
        imm_d        = imm_q;
        subtraindo_d = subtraindo_q;
        alu_src_d    = alu_src_q;
        operacao_d   = operacao_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            dina_d       = fwd_a;
            dinb_d       = fwd_b;
            imm_d        = in_imm;
            subtraindo_d = in_subtraindo;
            alu_src_d    = in_alu_src;
            operacao_d   = in_operacao;
            rd_d         = in_rd;
            reg_write_d  = in_reg_write;
            rs1_d        = in_rs1;
            rs2_d        = in_rs2;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: keep the held operands coherent with writebacks landing now.
            if (wb_fwd_ok && (wb_rd == rs1_q)) begin
                dina_d = wb_data;
            end
            if (wb_fwd_ok && (wb_rd == rs2_q)) begin
                dinb_d = wb_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            dina_q       <= '0;
            dinb_q       <= '0;
            imm_q        <= '0;
            subtraindo_q <= 1'b0;
            alu_src_q    <= 1'b0;
            operacao_q   <= 2'd0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            dina_q       <= dina_d;
            dinb_q       <= dinb_d;
            imm_q        <= imm_d;
            subtraindo_q <= subtraindo_d;
            alu_src_q    <= alu_src_d;
            operacao_q   <= operacao_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
        end
    end

    assign out_valid  = valid_q;
    assign dina       = dina_q;
    assign dinb       = dinb_q;
    assign imm        = imm_q;
    assign subtraindo = subtraindo_q;
    assign alu_src    = alu_src_q;
    assign operacao   = operacao_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q;

endmodule

// File: tb/tb_registrador_id_ex.sv
// Bench for registrador_id_ex: directed hazard/handshake scenarios followed by random
// traffic, all checked against a transaction-level model of the held instruction.
module tb_registrador_id_ex;

    localparam int BITS = 64;
    localparam int RA   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [RA-1:0]   in_rs1, in_rs2, in_rd;
    logic [BITS-1:0] in_dina, in_dinb, in_imm;
    logic            in_subtraindo, in_alu_src, in_reg_write;
    logic [1:0]      in_operacao;
    logic            flush;
    logic [BITS-1:0] ula_dout;
    logic            wb_valid;
    logic [RA-1:0]   wb_rd;
    logic [BITS-1:0] wb_data;
    logic            out_valid, out_ready;
    logic [BITS-1:0] dina, dinb, imm;
    logic            subtraindo, alu_src, reg_write;
    logic [1:0]      operacao;
    logic [RA-1:0]   rd;

    int vectors = 0;
    int miscompares = 0;

    registrador_id_ex #(.BITS(BITS), .REG_ADDR(RA)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_dina(in_dina), .in_dinb(in_dinb), .in_imm(in_imm),
        .in_subtraindo(in_subtraindo), .in_alu_src(in_alu_src),
        .in_operacao(in_operacao), .in_reg_write(in_reg_write),
        .flush(flush),
        .ula_dout(ula_dout), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .dina(dina), .dinb(dinb), .imm(imm),
        .subtraindo(subtraindo), .alu_src(alu_src), .operacao(operacao),
        .rd(rd), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    // Model: the one instruction the register currently holds, as a record.
    typedef struct {
        logic            valid;
        logic [BITS-1:0] a, b, imm;
        logic            sub, src, rw;
        logic [1:0]      op;
        logic [RA-1:0]   rd, rs1, rs2;
    } held_t;

    held_t m;

    function automatic held_t empty_held();
        held_t h;
        h.valid = 0; h.a = 0; h.b = 0; h.imm = 0; h.sub = 0; h.src = 0; h.rw = 0;
        h.op = 0; h.rd = 0; h.rs1 = 0; h.rs2 = 0;
        return h;
    endfunction

    // Newest value of register r as seen by the decode stage right now.
    function automatic logic [BITS-1:0] read_reg(input logic [RA-1:0] r, input logic [BITS-1:0] rf_val);
        if (r == 0) return rf_val;
        if (m.valid && m.rw && m.rd == r) return ula_dout;
        if (wb_valid && wb_rd == r) return wb_data;
        return rf_val;
    endfunction

    function automatic held_t next_held();
        held_t n;
        logic rdy;
        n = m;
        rdy = !m.valid || out_ready;
        if (reset) return empty_held();
        if (flush) begin
            n.valid = 0;
        end else if (in_valid && rdy) begin
            n.valid = 1;
            n.a = read_reg(in_rs1, in_dina);
            n.b = read_reg(in_rs2, in_dinb);
            n.imm = in_imm; n.sub = in_subtraindo; n.src = in_alu_src;
            n.op = in_operacao; n.rd = in_rd; n.rw = in_reg_write;
            n.rs1 = in_rs1; n.rs2 = in_rs2;
        end else if (out_ready) begin
            n.valid = 0;
        end else if (m.valid && wb_valid && wb_rd != 0) begin
            if (wb_rd == m.rs1) n.a = wb_data;
            if (wb_rd == m.rs2) n.b = wb_data;
        end
        return n;
    endfunction

    task automatic check64(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check64({tag, ".out_valid"}, 64'(out_valid), 64'(m.valid));
        check64({tag, ".in_ready"}, 64'(in_ready), 64'(!m.valid || out_ready));
        check64({tag, ".dina"}, dina, m.a);
        check64({tag, ".dinb"}, dinb, m.b);
        check64({tag, ".imm"}, imm, m.imm);
        check64({tag, ".subtraindo"}, 64'(subtraindo), 64'(m.sub));
        check64({tag, ".alu_src"}, 64'(alu_src), 64'(m.src));
        check64({tag, ".operacao"}, 64'(operacao), 64'(m.op));
        check64({tag, ".rd"}, 64'(rd), 64'(m.rd));
        check64({tag, ".reg_write"}, 64'(reg_write), 64'(m.rw));
    endtask

    // One clock: check the combinational ready, advance the model, check registered state.
    task automatic tick(input string tag);
        held_t n;
        #1;
        check64({tag, ".in_ready_pre"}, 64'(in_ready), 64'(!m.valid || out_ready));
        n = next_held();
        @(posedge clk);
        #1;
        m = n;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_dina = 0; in_dinb = 0;
        in_imm = 0; in_subtraindo = 0; in_alu_src = 0; in_operacao = 0; in_reg_write = 0;
        flush = 0; ula_dout = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic drive(input logic [RA-1:0] rs1, input logic [RA-1:0] rs2, input logic [RA-1:0] rdi,
                         input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic [BITS-1:0] im,
                         input logic src, input logic [1:0] op, input logic rw);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rdi; in_dina = a; in_dinb = b;
        in_imm = im; in_alu_src = src; in_operacao = op; in_reg_write = rw; in_subtraindo = 0;
    endtask

    initial begin
        m = empty_held();
        idle_inputs();
        reset = 1;
        #1;
        check_all("reset_async");
        tick("reset_hold");
        reset = 0;
        tick("after_reset");

        // Back-to-back capture, dina 5 then 9
        drive(3, 0, 1, 5, 0, 7, 1, 0, 1);
        tick("b2b_a");
        check64("b2b_a_dina", dina, 64'd5);
        drive(3, 0, 1, 9, 0, 7, 1, 0, 1);
        tick("b2b_b");
        check64("b2b_b_dina", dina, 64'd9);
        check64("b2b_b_valid", 64'(out_valid), 64'd1);

        // EX forward onto rs2, and the x0 exception
        drive(0, 0, 4, 1, 2, 0, 0, 0, 1);
        tick("exf_a");
        ula_dout = 64'h1234;
        drive(0, 4, 2, 0, 0, 0, 0, 0, 0);
        tick("exf_b");
        check64("exf_dinb", dinb, 64'h1234);
        drive(0, 0, 0, 1, 2, 0, 0, 0, 1);
        tick("exf0_a");
        drive(0, 0, 2, 0, 0, 0, 0, 0, 0);
        tick("exf0_b");
        check64("exf0_dinb", dinb, 64'd0);

        // EX beats WB for the same register
        drive(0, 0, 6, 0, 0, 0, 0, 0, 1);
        tick("prio_a");
        ula_dout = 64'hAA; wb_valid = 1; wb_rd = 6; wb_data = 64'hBB;
        drive(6, 0, 2, 3, 0, 0, 0, 1, 0);
        tick("prio_b");
        check64("prio_dina", dina, 64'hAA);
        wb_valid = 0; ula_dout = 0;

        // Stall with writeback update of the held rs1
        drive(8, 9, 2, 1, 2, 0, 0, 2, 1);
        tick("stall_cap");
        out_ready = 0;
        drive(1, 1, 1, 64'hDEAD, 64'hBEEF, 5, 1, 3, 1);
        tick("stall_c1");
        check64("stall_c1_in_ready", 64'(in_ready), 64'd0);
        wb_valid = 1; wb_rd = 8; wb_data = 64'h55;
        tick("stall_c2");
        check64("stall_c2_dina", dina, 64'h55);
        wb_valid = 0;
        tick("stall_c3");
        check64("stall_c3_dina", dina, 64'h55);
        check64("stall_c3_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
        tick("stall_release");

        // Flush with a held instruction and a new one offered
        drive(2, 2, 3, 64'h77, 64'h66, 1, 0, 1, 1);
        tick("flush_cap");
        drive(4, 4, 5, 64'h99, 64'h88, 2, 1, 2, 0);
        flush = 1;
        tick("flush");
        check64("flush_valid", 64'(out_valid), 64'd0);
        check64("flush_dina_hold", dina, 64'h77);
        flush = 0;

        // Reset asserted mid-cycle while holding an instruction
        drive(1, 2, 3, 64'h11, 64'h22, 64'h33, 1, 2, 1);
        tick("rst_cap");
        out_ready = 0;
        #3;
        reset = 1;
        #1;
        m = empty_held();
        check_all("rst_mid");
        check64("rst_mid_in_ready", 64'(in_ready), 64'd1);
        tick("rst_hold");
        reset = 0;
        out_ready = 1;
        idle_inputs();
        tick("rst_release");

        // Random traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_rs1        = RA'($urandom_range(0, 7));
            in_rs2        = RA'($urandom_range(0, 7));
            in_rd         = RA'($urandom_range(0, 7));
            in_dina       = {$urandom, $urandom};
            in_dinb       = {$urandom, $urandom};
            in_imm        = {$urandom, $urandom};
            in_subtraindo = 1'($urandom_range(0, 1));
            in_alu_src    = 1'($urandom_range(0, 1));
            in_operacao   = 2'($urandom_range(0, 3));
            in_reg_write  = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 9) == 0);
            ula_dout      = {$urandom, $urandom};
            wb_valid      = 1'($urandom_range(0, 1));
            wb_rd         = RA'($urandom_range(0, 7));
            wb_data       = {$urandom, $urandom};
            out_ready     = ($urandom_range(0, 2) != 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/registrador_id_ex.md
# registrador_id_ex

- Pipeline register directly upstream of the 64-bit ULA (`ULA` instance).
- Captures decoded operands and control from the decode/register-read stage behind a valid/ready handshake.
- Resolves data hazards by forwarding from the ULA result and from writeback.
- Drives the ULA's `dina`, `dinb`, `imm`, `subtraindo`, `alu_src` and `operacao` inputs from registered state, so the ULA sees stable operands for a whole cycle.

## Interface
Parameters:
- `BITS`, 64, datapath width; must match the ULA.
- `REG_ADDR`, 5, register-index width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  upstream holds a valid decoded instruction.
- `in_ready`  out  1  block accepts the upstream instruction this cycle.
- `in_rs1`, `in_rs2`, `in_rd`  in  REG_ADDR  source/destination register indices.
- `in_dina`, `in_dinb`  in  BITS  register-file read data for rs1/rs2.
- `in_imm`  in  BITS  sign-extended immediate.
- `in_subtraindo`  in  1  add/subtract select.
- `in_alu_src`  in  1  1 = ULA operand B is the immediate.
- `in_operacao`  in  2  0 = soma/sub, 1 = AND, 2 = OR.
- `in_reg_write`  in  1  instruction writes `rd`.
- `flush`  in  1  discard the held instruction and any capture this cycle.
- `ula_dout`  in  BITS  ULA result for the currently held instruction, fed back.
- `wb_valid`  in  1  writeback stage writes this cycle.
- `wb_rd`  in  REG_ADDR  writeback destination.
- `wb_data`  in  BITS  writeback data.
- `out_valid`  out  1  ULA inputs hold a valid instruction.
- `out_ready`  in  1  downstream consumes the held instruction this cycle.
- `dina`, `dinb`, `imm`  out  BITS  to the ULA.
- `subtraindo`, `alu_src`  out  1  to the ULA.
- `operacao`  out  2  to the ULA.
- `rd`  out  REG_ADDR  held destination.
- `reg_write`  out  1  held write enable.

## Operation
- `in_ready = !out_valid || out_ready` (combinational).
- Accept: `in_valid && in_ready && !flush`. On the edge, all outputs load from `in_*`, with `dina`/`dinb` taken from the forwarding mux. `out_valid <= 1`.
- Retire without accept: `out_ready && !(in_valid && in_ready)` sets `out_valid <= 0`; all data outputs hold their values.
- Stall: `out_valid && !out_ready`. All outputs hold except held-operand writeback update (see below).
- `flush` beats everything: `out_valid <= 0`, no capture, data outputs hold.
- Forwarding mux, per source (rs1 → `dina`, rs2 → `dinb`), priority highest first:
  1. EX forward: `out_valid && reg_write && rd != 0 && rd == in_rsN` selects `ula_dout`.
  2. WB forward: `wb_valid && wb_rd != 0 && wb_rd == in_rsN` selects `wb_data`.
  3. Otherwise `in_dinX`.
- Index 0 never forwards; register x0 always reads `in_dinX`.
- Held rs1/rs2 are stored internally.
- Held-operand update while stalled: if `wb_valid && wb_rd != 0 && wb_rd` matches held rs1 (rs2), `dina` (`dinb`) loads `wb_data`. This applies to both fields independently.
- `imm` is captured regardless of `in_alu_src`.
- `operacao` = 3 passes through unchanged.
- No arithmetic is performed here; all widths pass through unchanged.

## Timing
- Reset (async assert, sync release): `out_valid = 0`; `dina`, `dinb`, `imm`, `rd` = 0; `subtraindo`, `alu_src`, `reg_write` = 0; `operacao` = 0. `in_ready` = 1 while `out_valid` = 0.
- Reset asserted mid-stall drops the held instruction; no output glitches to a partial value.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction/cycle while `out_ready` = 1.
- `ula_dout` is sampled on the same edge the held instruction retires. EX forwarding is valid only because accept implies `out_ready` or an empty register.
- Accept and stall-update conflict cannot occur: accept reloads `dina`/`dinb` entirely.
- `flush` together with `in_valid`: instruction dropped, `in_ready` still reflects the formula, upstream must treat it as consumed.

## Test plan
- Reset: assert `reset` mid-cycle with `out_valid` = 1. Required: `out_valid` = 0 and all outputs 0 immediately; `in_ready` = 1.
- Back-to-back: instr A (rs1 = 3, `in_dina` = 5, imm = 7, `alu_src` = 1, op = 0) then B (`in_dina` = 9), `out_ready` = 1. Required: `dina` = 5 at cycle 1, then 9; `out_valid` stays 1.
- EX forward: A writes rd = 4, `ula_dout` = 0x1234. Next B has rs2 = 4, `in_dinb` = 0. Required: B's `dinb` = 0x1234. Repeat with rd = 0: B's `dinb` = 0.
- Priority: EX (rd = 6, `ula_dout` = 0xAA) and WB (`wb_rd` = 6, `wb_data` = 0xBB) both match rs1 = 6. Required: `dina` = 0xAA.
- Stall update: hold B (rs1 = 8) with `out_ready` = 0 for 3 cycles; WB writes r8 = 0x55 in cycle 2. Required: `dina` = 0x55 from cycle 3; `in_ready` = 0 throughout the stall.
- Flush: `flush` = 1 with `in_valid` = 1 and a held instruction. Required: next cycle `out_valid` = 0 and nothing is captured.
